// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Purpose:
//   Collects the system reset sources (debounced button, HPS h2f_reset),
//   synchronizes each into clk, waits for a programmable quiet period in
//   which no source requests reset, and then releases a set of active-low
//   reset outputs one at a time with a fixed gap between them. When every
//   output is released the block reports ready. Any request seen at any
//   point drops every output low again and restarts the whole sequence.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth per source (>= 2)
//   HOLD_CYCLES  consecutive request-free cycles before the first release (>= 1)
//   STAGE_GAP    cycles between successive output releases (>= 1)
//   NUM_OUTS     number of sequenced reset outputs (>= 1)
//   CNT_WIDTH    width of the hold and gap counters
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset (driven from ~ninit_done)
//   rst_req_n    in   debounced button reset, active-low, asynchronous to clk
//   h2f_reset    in   HPS-to-FPGA reset, active-high, asynchronous to clk
//   rst_out_n    out  [NUM_OUTS] sequenced resets, active-low, bit 0 first
//   ready        out  high once every output is released (RUN state)
//
// Optional feature (macro RESET_SEQ_CAUSE_EN):
//   last_cause   out  [2] synced request levels latched on each re-entry to
//                     ASSERT (bit0 = button, bit1 = HPS)
//   reset_count  out  [16] saturating count of re-entries to ASSERT; the
//                     power-on ASSERT is not counted
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_CYCLES = 10000,
    parameter int STAGE_GAP   = 16,
    parameter int NUM_OUTS    = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rst_req_n,
    input  logic                h2f_reset,
    output logic [NUM_OUTS-1:0] rst_out_n,
`ifdef RESET_SEQ_CAUSE_EN
    output logic [1:0]          last_cause,
    output logic [15:0]         reset_count,
`endif
    output logic                ready
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("reset_sequencer: SYNC_STAGES must be at least 2");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_sequencer: HOLD_CYCLES must be at least 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("reset_sequencer: STAGE_GAP must be at least 1");
    end
    if (NUM_OUTS < 1) begin : g_chk_outs
        $error("reset_sequencer: NUM_OUTS must be at least 1");
    end
    if ((((HOLD_CYCLES - 1) >> CNT_WIDTH) != 0) ||
        (((STAGE_GAP - 1) >> CNT_WIDTH) != 0)) begin : g_chk_cnt
        $error("reset_sequencer: CNT_WIDTH too small for HOLD_CYCLES/STAGE_GAP");
    end

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int IDX_W = (NUM_OUTS > 1) ? $clog2(NUM_OUTS) : 1;

    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_OUTS - 1);
    localparam logic [NUM_OUTS-1:0]  OUT_ONE   = NUM_OUTS'(1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2,
        ST_RUN     = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // Source synchronizers
    //
    // Both chains are preset to "request active" so that, coming out of
    // reset_n, the FSM sees a request until real input levels have walked
    // through the full chain. This guarantees the hold period is always
    // measured on synchronized levels.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] hps_sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_sync_q <= '0;
            hps_sync_q <= '1;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], rst_req_n};
            hps_sync_q <= {hps_sync_q[SYNC_STAGES-2:0], h2f_reset};
        end
    end

    logic btn_req;
    logic hps_req;
    logic req;

    assign btn_req = ~btn_sync_q[SYNC_STAGES-1];
    assign hps_req =  hps_sync_q[SYNC_STAGES-1];
    assign req     = btn_req | hps_req;

    // -------------------------------------------------------------------------
    // Sequencing FSM
    //
    // A synchronized request overrides everything else in the same cycle, so
    // a terminal count coinciding with a request never releases an output.
    // Counters are cleared on every state change, so they never wrap.
    // -------------------------------------------------------------------------
    state_e                state_q;
    logic [CNT_WIDTH-1:0]  hold_cnt_q;
    logic [CNT_WIDTH-1:0]  gap_cnt_q;
    logic [IDX_W-1:0]      stage_q;
    logic [NUM_OUTS-1:0]   rst_out_q;
    logic                  ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stage_q    <= '0;
            rst_out_q  <= '0;
            ready_q    <= 1'b0;
        end else if (req) begin
            state_q    <= ST_ASSERT;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            stage_q    <= '0;
            rst_out_q  <= '0;
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_q    <= ST_HOLD;
                    hold_cnt_q <= '0;
                end

                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= ST_RELEASE;
                        hold_cnt_q <= '0;
                        gap_cnt_q  <= '0;
                        stage_q    <= '0;
                        rst_out_q  <= OUT_ONE;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end

                ST_RELEASE: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q <= '0;
                        if (stage_q < LAST_IDX) begin
                            stage_q   <= stage_q + 1'b1;
                            // Outputs form a thermometer code: shifting in a
                            // one releases exactly the next bit up.
                            rst_out_q <= (rst_out_q << 1) | OUT_ONE;
                        end else begin
                            state_q <= ST_RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    // Outputs stay released until a request arrives.
                end

                default: begin
                    state_q    <= ST_ASSERT;
                    hold_cnt_q <= '0;
                    gap_cnt_q  <= '0;
                    stage_q    <= '0;
                    rst_out_q  <= '0;
                    ready_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rst_out_n = rst_out_q;
    assign ready     = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
    // -------------------------------------------------------------------------
    // Reset cause capture
    //
    // A request while not in ASSERT is exactly a transition into ASSERT from
    // HOLD, RELEASE or RUN; the power-on ASSERT and a request that simply
    // persists inside ASSERT are therefore not counted.
    // -------------------------------------------------------------------------
    logic [1:0]  cause_q;
    logic [15:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q <= 2'b00;
            count_q <= 16'h0000;
        end else if (req && (state_q != ST_ASSERT)) begin
            cause_q <= {hps_req, btn_req};
            if (count_q != 16'hFFFF) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign last_cause  = cause_q;
    assign reset_count = count_q;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = 8;
  localparam int GAP  = 4;
  localparam int NO   = 3;
  localparam int QMAX = HOLD + 1 + NO * GAP;

  logic          clk       = 1'b0;
  logic          reset_n   = 1'b1;
  logic          rst_req_n = 1'b1;
  logic          h2f_reset = 1'b0;
  logic [NO-1:0] rst_out_n;
  logic          ready;
`ifdef RESET_SEQ_CAUSE_EN
  logic [1:0]    last_cause;
  logic [15:0]   reset_count;
`endif

  reset_sequencer #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP),
    .NUM_OUTS   (NO),
    .CNT_WIDTH  (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rst_req_n  (rst_req_n),
    .h2f_reset  (h2f_reset),
    .rst_out_n  (rst_out_n),
`ifdef RESET_SEQ_CAUSE_EN
    .last_cause (last_cause),
    .reset_count(reset_count),
`endif
    .ready      (ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the block is characterized by the number of consecutive
  // clock edges at which the (delayed) request level has been inactive.
  // The synchronized view at edge k is the raw level sampled SYNC edges
  // earlier; right after reset the view reads "request active".
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [NO-1:0] rst;
    logic          rdy;
    logic [1:0]    cause;
    logic [15:0]   cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] hist[$];
  int         quiet   = 0;
  logic [1:0] m_cause = 2'b00;
  int         m_count = 0;

  function automatic exp_t model_out(int q, logic [1:0] c, int n);
    exp_t e;
    int   rel;
    if (q < HOLD + 1) rel = 0;
    else begin
      rel = 1 + (q - HOLD - 1) / GAP;
      if (rel > NO) rel = NO;
    end
    e.rst   = NO'((1 << rel) - 1);
    e.rdy   = (q >= QMAX);
    e.cause = c;
    e.cnt   = 16'(n);
    return e;
  endfunction

  always @(posedge clk) begin
    logic [1:0] view;
    if (!reset_n) begin
      hist.delete();
      quiet   = 0;
      m_cause = 2'b00;
      m_count = 0;
    end else begin
      hist.push_back({h2f_reset, ~rst_req_n});
      if (hist.size() > SYNC) view = hist.pop_front();
      else                    view = 2'b11;
      if (view != 2'b00) begin
        if (quiet > 0) begin
          m_cause = view;
          if (m_count < 65535) m_count++;
        end
        quiet = 0;
      end else if (quiet < QMAX) begin
        quiet++;
      end
    end
    exp_q.push_back(model_out(quiet, m_cause, m_count));
  end

  // Monitor: pops one expectation per clock and compares away from the edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mon_rst_out_n", 32'(rst_out_n), 32'(e.rst));
      chk("mon_ready", 32'(ready), 32'(e.rdy));
`ifdef RESET_SEQ_CAUSE_EN
      chk("mon_last_cause", 32'(last_cause), 32'(e.cause));
      chk("mon_reset_count", 32'(reset_count), 32'(e.cnt));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rst_out_n", 32'(rst_out_n), 32'h0);
    chk("reset_ready", 32'(ready), 32'h0);

    // Power-up: edges counted from reset_n release
    #1 reset_n = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 10) chk("pwr_e10", 32'(rst_out_n), 32'h0);
      if (k == 11) chk("pwr_e11", 32'(rst_out_n), 32'h1);
      if (k == 14) chk("pwr_e14", 32'(rst_out_n), 32'h1);
      if (k == 15) chk("pwr_e15", 32'(rst_out_n), 32'h3);
      if (k == 18) chk("pwr_e18", 32'(rst_out_n), 32'h3);
      if (k == 19) chk("pwr_e19", 32'(rst_out_n), 32'h7);
      if (k == 22) chk("pwr_ready_e22", 32'(ready), 32'h0);
      if (k == 23) chk("pwr_ready_e23", 32'(ready), 32'h1);
    end

    // Button pulse in RUN, glitch in HOLD, request during RELEASE
    for (int k = 1; k <= 52; k++) begin
      @(negedge clk);
      rst_req_n = !(k == 1 || (k >= 24 && k <= 26));
      h2f_reset = (k == 8);
      @(posedge clk); #1;
      if (k == 2)  chk("btn_e2_hold", 32'({ready, rst_out_n}), 32'hF);
      if (k == 3)  chk("btn_e3_low", 32'({ready, rst_out_n}), 32'h0);
      if (k == 12) chk("glitch_no_early", 32'(rst_out_n), 32'h0);
      if (k == 18) chk("glitch_e18", 32'(rst_out_n), 32'h0);
      if (k == 19) chk("glitch_e19", 32'(rst_out_n), 32'h1);
      if (k == 25) chk("rel_req_e2", 32'(rst_out_n), 32'h3);
      if (k == 26) chk("rel_req_e3", 32'({ready, rst_out_n}), 32'h0);
      if (k == 36) chk("rel_req_e36", 32'(rst_out_n), 32'h0);
      if (k == 37) chk("rel_req_e37", 32'(rst_out_n), 32'h1);
      if (k == 49) chk("rel_req_ready", 32'(ready), 32'h1);
    end

    // Asynchronous reset in RUN, checked before any further clock edge
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out_n", 32'(rst_out_n), 32'h0);
    chk("async_ready", 32'(ready), 32'h0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;

    // Cause capture: HPS reset then button reset
    for (int k = 1; k <= 90; k++) begin
      @(negedge clk);
      h2f_reset = (k == 30);
      rst_req_n = !(k == 60);
      @(posedge clk); #1;
      if (k == 29) chk("cause_pre_ready", 32'(ready), 32'h1);
`ifdef RESET_SEQ_CAUSE_EN
      if (k == 29) chk("cause_pre_cnt", 32'(reset_count), 32'h0);
      if (k == 40) chk("cause_hps", 32'(last_cause), 32'h2);
      if (k == 40) chk("cause_cnt1", 32'(reset_count), 32'h1);
      if (k == 70) chk("cause_btn", 32'(last_cause), 32'h1);
      if (k == 70) chk("cause_cnt2", 32'(reset_count), 32'h2);
`endif
    end

    // Randomized traffic: quiet runs, request bursts, occasional reset_n
    for (int b = 0; b < 40; b++) begin
      int mode;
      int len;
      mode = $urandom_range(0, 9);
      if (mode < 6) begin
        len = $urandom_range(1, 35);
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          rst_req_n = 1'b1;
          h2f_reset = 1'b0;
        end
      end else if (mode < 9) begin
        len = $urandom_range(1, 4);
        for (int i = 0; i < len; i++) begin
          @(negedge clk);
          rst_req_n = 1'($urandom_range(0, 1));
          h2f_reset = 1'($urandom_range(0, 1));
        end
      end else begin
        @(negedge clk);
        #2 reset_n = 1'b0;
        len = $urandom_range(1, 3);
        repeat (len) @(negedge clk);
        #2 reset_n = 1'b1;
      end
    end

    @(negedge clk);
    rst_req_n = 1'b1;
    h2f_reset = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
